// File: rtl/pb_pkg.sv
// Shared types and default timing constants for the push-button press classifier.
package pb_pkg;

    localparam int unsigned PB_LONG_CYCLES = 50_000_000;
    localparam int unsigned PB_GAP_CYCLES  = 12_500_000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } pb_state_e;

endpackage

// File: rtl/pb_press_classifier.sv
// Classifies debounced press/release pulses into short, long and double presses.
module pb_press_classifier
    import pb_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = PB_LONG_CYCLES,
    parameter int unsigned GAP_CYCLES  = PB_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic long_held
);

    localparam int unsigned MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    pb_state_e        state;
    pb_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             short_nxt;
    logic             long_nxt;
    logic             double_nxt;

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            long_held    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_press <= double_nxt;
            long_held    <= (state_nxt == LONG_HELD);
        end
    end

    // Release/press edges win over timeouts; the opposite input is ignored per state
    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pb_down) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (pb_up) begin
                    state_nxt = WAIT2;
                end else if (cnt == LONG_LAST) begin
                    state_nxt = LONG_HELD;
                    long_nxt  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (pb_up) state_nxt = IDLE;
            end
            WAIT2: begin
                if (pb_down) begin
                    state_nxt = PRESS2;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (pb_up) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == PRESS1 || state == WAIT2) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end
    end

endmodule

// File: tb/tb_pb_press_classifier.sv
// Directed self-checking bench for pb_press_classifier with LONG_CYCLES=20, GAP_CYCLES=10.
module tb_pb_press_classifier;

    logic clk = 1'b0;
    logic rst_n;
    logic pb_down;
    logic pb_up;
    logic short_press;
    logic long_press;
    logic double_press;
    logic long_held;

    int n_chk = 0;
    int n_bad = 0;

    int t;
    int n_short, n_long, n_dbl, n_held, n_multi;
    int first_short, first_long, first_dbl, first_held;

    pb_press_classifier #(
        .LONG_CYCLES(20),
        .GAP_CYCLES (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pb_down     (pb_down),
        .pb_up       (pb_up),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .long_held   (long_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        n_short = 0; n_long = 0; n_dbl = 0; n_held = 0; n_multi = 0;
        first_short = -1; first_long = -1; first_dbl = -1; first_held = -1;
        t = 0;
    endtask

    // Drive inputs on the falling edge, sample outputs 1 time unit after the rising edge
    task automatic tick(input logic dn, input logic up);
        @(negedge clk);
        pb_down = dn;
        pb_up   = up;
        @(posedge clk);
        #1;
        t++;
        if (short_press)  begin n_short++; if (first_short < 0) first_short = t; end
        if (long_press)   begin n_long++;  if (first_long  < 0) first_long  = t; end
        if (double_press) begin n_dbl++;   if (first_dbl   < 0) first_dbl   = t; end
        if (long_held)    begin n_held++;  if (first_held  < 0) first_held  = t; end
        if (int'(short_press) + int'(long_press) + int'(double_press) > 1) n_multi++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        pb_down = 1'b0;
        pb_up   = 1'b0;
        rst_n   = 1'b0;
        clr_stats();
        #1;
        chk("rst_short", int'(short_press), 0);
        chk("rst_long", int'(long_press), 0);
        chk("rst_double", int'(double_press), 0);
        chk("rst_held", int'(long_held), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Short press: release 5 cycles after press, short_press 10 cycles after release
        clr_stats();
        tick(1'b1, 1'b0);
        idle(4);
        t = -1;
        tick(1'b0, 1'b1);
        idle(15);
        chk("short_when", first_short, 10);
        chk("short_count", n_short, 1);
        chk("short_no_long", n_long, 0);
        chk("short_no_dbl", n_dbl, 0);

        // Long press: held 30 cycles
        clr_stats();
        t = -1;
        tick(1'b1, 1'b0);
        idle(29);
        tick(1'b0, 1'b1);
        chk("long_held_fall", int'(long_held), 0);
        idle(15);
        chk("long_when", first_long, 20);
        chk("long_count", n_long, 1);
        chk("held_rise", first_held, 20);
        chk("held_cycles", n_held, 10);
        chk("long_no_short", n_short, 0);

        // Double press
        clr_stats();
        tick(1'b1, 1'b0);
        idle(4);
        tick(1'b0, 1'b1);
        idle(3);
        tick(1'b1, 1'b0);
        idle(2);
        t = -1;
        tick(1'b0, 1'b1);
        idle(15);
        chk("dbl_when", first_dbl, 0);
        chk("dbl_count", n_dbl, 1);
        chk("dbl_no_short", n_short, 0);
        chk("dbl_no_long", n_long, 0);

        // Boundary: release at counter 19, press again at gap counter 9
        clr_stats();
        tick(1'b1, 1'b0);
        idle(19);
        tick(1'b0, 1'b1);
        idle(9);
        tick(1'b1, 1'b0);
        idle(3);
        tick(1'b0, 1'b1);
        idle(12);
        chk("edge_no_long", n_long, 0);
        chk("edge_no_held", n_held, 0);
        chk("edge_no_short", n_short, 0);
        chk("edge_dbl", n_dbl, 1);

        // Both inputs high: IDLE takes the press, PRESS1 takes the release
        clr_stats();
        tick(1'b1, 1'b1);
        t = -1;
        tick(1'b1, 1'b1);
        idle(15);
        chk("both_short_when", first_short, 10);
        chk("both_no_dbl", n_dbl, 0);

        // Async reset while in WAIT2
        clr_stats();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_w2_short", int'(short_press), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(15);
        tick(1'b0, 1'b1);
        idle(15);
        chk("rst_w2_quiet", n_short + n_long + n_dbl + n_held, 0);

        // Async reset while in LONG_HELD
        clr_stats();
        tick(1'b1, 1'b0);
        idle(22);
        chk("pre_rst_held", int'(long_held), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_lh_held", int'(long_held), 0);
        chk("rst_lh_long", int'(long_press), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_stats();
        tick(1'b0, 1'b1);
        idle(25);
        chk("rst_lh_quiet", n_short + n_long + n_dbl + n_held, 0);
        chk("onehot", n_multi, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pb_press_classifier.md
PB_PRESS_CLASSIFIER -- requirements
Module: pb_press_classifier

Interface
REQ-001 Parameter LONG_CYCLES, default 50_000_000: hold duration in clk cycles (1 s at 50 MHz) that classifies a press as long; legal range >= 2.
REQ-002 Parameter GAP_CYCLES, default 12_500_000: maximum release-to-press gap in clk cycles (250 ms) for a double press; legal range >= 2.
REQ-003 clk  input  1  system clock; all logic samples on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pb_down  input  1  one-cycle pulse from the debouncer: button just pressed.
REQ-006 pb_up  input  1  one-cycle pulse from the debouncer: button just released.
REQ-007 short_press  output  1  one-cycle pulse: single press released before LONG_CYCLES, with no second press within GAP_CYCLES.
REQ-008 long_press  output  1  one-cycle pulse: press held for LONG_CYCLES.
REQ-009 double_press  output  1  one-cycle pulse: second press released.
REQ-010 long_held  output  1  level, high while in LONG_HELD.

Function
REQ-011 The FSM SHALL have exactly five states: IDLE, PRESS1, LONG_HELD, WAIT2, PRESS2.
REQ-012 A single counter, width $clog2(max(LONG_CYCLES,GAP_CYCLES))+1, SHALL clear to 0 on every state transition and otherwise increment by 1 each cycle in PRESS1 and WAIT2; it holds its value in all other states.
REQ-013 IDLE: pb_down -> PRESS1; pb_up ignored.
REQ-014 PRESS1: pb_up -> WAIT2; else counter == LONG_CYCLES-1 -> LONG_HELD with long_press pulse.
REQ-015 LONG_HELD: pb_up -> IDLE; pb_down ignored.
REQ-016 WAIT2: pb_down -> PRESS2; else counter == GAP_CYCLES-1 -> IDLE with short_press pulse.
REQ-017 PRESS2: pb_up -> IDLE with double_press pulse; no long classification in PRESS2.
REQ-018 In PRESS1, pb_up SHALL take priority over reaching the LONG_CYCLES-1 count in the same cycle; in WAIT2, pb_down SHALL take priority over reaching the GAP_CYCLES-1 count.
REQ-019 If pb_down and pb_up are both high in the same cycle, the input that matches the current state's exit condition SHALL be acted on and the other ignored.
REQ-020 All outputs SHALL be registered; pulses SHALL be high for exactly the one cycle after the clock edge that performs the transition.
REQ-021 At most one of short_press, long_press, double_press SHALL be high in any cycle.
REQ-022 long_held SHALL rise with long_press and fall on the edge that leaves LONG_HELD.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, and all outputs 0, regardless of the current state.
REQ-024 After rst_n is released, a pb_up without a preceding pb_down SHALL produce no output.

Structure
REQ-025 The state enum typedef and the default LONG_CYCLES / GAP_CYCLES constants SHALL live in shared package pb_pkg.
REQ-026 No sub-module; the FSM and counter are in one module, directly fed by the debouncer's pb_down/pb_up.

Verification (LONG_CYCLES=20, GAP_CYCLES=10)
REQ-027 pb_down, pb_up 5 cycles later, idle -> short_press single pulse exactly 10 cycles after pb_up; no other pulse.
REQ-028 pb_down, hold 30 cycles -> long_press pulse 20 cycles after pb_down, long_held high until the cycle after pb_up; no short_press.
REQ-029 pb_down, pb_up at +5, pb_down 4 cycles later, pb_up 3 cycles later -> double_press pulse one cycle after the second pb_up; no short_press.
REQ-030 pb_up coincident with counter == 19 in PRESS1 -> WAIT2 entered, no long_press; pb_down coincident with counter == 9 in WAIT2 -> PRESS2 entered, no short_press.
REQ-031 rst_n pulsed low in WAIT2 and in LONG_HELD -> outputs 0 asynchronously, state IDLE; a following lone pb_up produces nothing.
